shift_sub_divider: RTL and testbench

//  Sequential restoring (shift-and-subtract) unsigned divider: 2N-bit dividend / N-bit divisor
//  -> N-bit quotient + N-bit remainder, with overflow flag. Inverse of the shift-add multiplier

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 19 +
 rtl/shift_sub_divider.sv | 107 ++++++++++
 tb/tb_shift_sub_divider.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the shift-and-subtract divider: FSM state encoding and
// the width of the step counter.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CHK  = 3'd1,
    SH   = 3'd2,
    SUB  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Counter must be able to hold the value n itself.
  function automatic int CNT_W(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: compares the upper accumulator slice against the
// divisor and provides the difference for the conditional subtract.
module div_step #(
  parameter int N = 4
) (
  input  logic [N:0]   acc_hi,
  input  logic [N-1:0] divisor,
  output logic         ge,
  output logic [N:0]   diff
);

  logic [N:0] divisor_ext;

  // Full N+1-bit compare so the shifted-out guard bit takes part in the decision.
  assign divisor_ext = {1'b0, divisor};
  assign ge          = (acc_hi >= divisor_ext);
  assign diff        = acc_hi - divisor_ext;

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient
// and remainder, with overflow flag and the St/Idle/Load/Done handshake.
module shift_sub_divider
  import div_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           St,
  input  logic [2*N-1:0] Dividend,
  input  logic [N-1:0]   Divisor,
  output logic [N-1:0]   Quotient,
  output logic [N-1:0]   Remainder,
  output logic           V,
  output logic           Idle,
  output logic           Load,
  output logic           Done
);

  localparam int CW = CNT_W(N);

  state_t        state_q, state_d;
  logic [2*N:0]  acc_q, acc_d;
  logic [N-1:0]  div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          v_q, v_d;

  logic          ge;
  logic [N:0]    diff;

  div_step #(.N(N)) u_step (
    .acc_hi  (acc_q[2*N:N]),
    .divisor (div_q),
    .ge      (ge),
    .diff    (diff)
  );

  always_comb begin
    // NOTE: every _d signal takes its hold value first, so no path through the case can infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    v_d     = v_q;

    unique case (state_q)
      IDLE: begin
        if (St) begin
          acc_d   = {1'b0, Dividend};
          div_d   = Divisor;
          cnt_d   = '0;
          v_d     = 1'b0;
          state_d = CHK;
        end
      end
      // The guard bit is still 0 here, so ge is the upper-half >= divisor test.
      CHK: begin
        if (ge) begin
          v_d     = 1'b1;
          state_d = DONE;
        end else begin
          state_d = SH;
        end
      end
      SH: begin
        acc_d   = {acc_q[2*N-1:0], 1'b0};
        cnt_d   = cnt_q + CW'(1);
        state_d = SUB;
      end
      SUB: begin
        if (ge) begin
          acc_d[2*N:N] = diff;
          acc_d[0]     = 1'b1;
        end
        state_d = (cnt_q == CW'(N)) ? DONE : SH;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      v_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      state_q <= state_d;
      acc_q   <= acc_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
    end
  end

  assign Quotient  = acc_q[N-1:0];
  assign Remainder = acc_q[2*N-1:N];
  assign V         = v_q;
  assign Idle      = (state_q == IDLE);
  assign Load      = Idle && St;
  assign Done      = (state_q == DONE);

endmodule

// File: tb/tb_shift_sub_divider.sv
// Randomized self-checking bench for shift_sub_divider (N=4) against an arithmetic
// model of operation results, latency and handshake.
module tb_shift_sub_divider;

  localparam int N = 4;

  logic           Clk;
  logic           Rst;
  logic           St;
  logic [2*N-1:0] Dividend;
  logic [N-1:0]   Divisor;
  logic [N-1:0]   Quotient;
  logic [N-1:0]   Remainder;
  logic           V;
  logic           Idle;
  logic           Load;
  logic           Done;

  int n_checks = 0;
  int n_pass   = 0;
  int edges    = 0;

  shift_sub_divider #(.N(N)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .St        (St),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .V         (V),
    .Idle      (Idle),
    .Load      (Load),
    .Done      (Done)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) edges <= edges + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit model_ovf(input int a, input int b);
    return (b == 0) || ((a / (1 << N)) >= b);
  endfunction

  // Packs {V, Remainder, Quotient} as the outputs must read at Done.
  function automatic logic [2*N:0] model_res(input int a, input int b);
    if (model_ovf(a, b)) return {1'b1, N'(a / (1 << N)), N'(a % (1 << N))};
    return {1'b0, N'(a % b), N'(a / b)};
  endfunction

  function automatic int model_lat(input int a, input int b);
    return model_ovf(a, b) ? 2 : 2 * N + 2;
  endfunction

  bit           busy      = 1'b0;
  int           m_edge    = 0;
  int           done_edge = 0;
  logic [N-1:0] last_q    = '0;
  logic [N-1:0] last_r    = '0;
  logic         last_v    = 1'b0;

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      busy   <= 1'b0;
      last_q <= '0;
      last_r <= '0;
      last_v <= 1'b0;
    end else begin
      m_edge <= m_edge + 1;
      if (busy) begin
        if (m_edge == done_edge) busy <= 1'b0;
      end else if (St) begin
        {last_v, last_r, last_q} <= model_res(int'(Dividend), int'(Divisor));
        done_edge <= m_edge + model_lat(int'(Dividend), int'(Divisor));
        busy      <= 1'b1;
      end
    end
  end

  // Compare process: handshake every cycle, results whenever they must be stable.
  always @(negedge Clk) begin
    check("done", Done, busy && (m_edge == done_edge));
    check("idle", Idle, !busy);
    check("load", Load, !busy && St);
    if (!busy || (m_edge == done_edge)) begin
      check("v", V, last_v);
      if (!last_v || !busy) begin
        check("quotient", Quotient, last_q);
        check("remainder", Remainder, last_r);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic run_op(input logic [2*N-1:0] dd, input logic [N-1:0] dv,
                        output int lat, output logic [N-1:0] q, output logic [N-1:0] r,
                        output logic v);
    int e0;
    int waited;
    tick();
    St       = 1'b1;
    Dividend = dd;
    Divisor  = dv;
    e0       = edges;
    tick();
    St       = 1'b0;
    Dividend = 8'($urandom);
    Divisor  = 4'($urandom);
    waited   = 0;
    while (!Done && waited < 40) begin
      tick();
      waited++;
    end
    if (!Done) check("done_timeout", 0, 1);
    lat = edges - e0;
    q   = Quotient;
    r   = Remainder;
    v   = V;
  endtask

  initial begin
    int           lat;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         v;
    int           dones;
    logic [2*N-1:0] dd;
    logic [N-1:0]   dv;

    Rst = 1'b0; St = 1'b0; Dividend = '0; Divisor = '0;
    #1 Rst = 1'b1;
    #1;
    check("rst_quotient", Quotient, 0);
    check("rst_remainder", Remainder, 0);
    check("rst_v", V, 0);
    check("rst_idle", Idle, 1);
    check("rst_done", Done, 0);
    repeat (2) @(posedge Clk);
    #2 Rst = 1'b0;

    run_op(8'h87, 4'hD, lat, q, r, v);
    check("lit_135_lat", lat, 10);
    check("lit_135_q", q, 10);
    check("lit_135_r", r, 5);
    check("lit_135_v", v, 0);

    run_op(8'hC3, 4'hD, lat, q, r, v);
    check("lit_195_q", q, 15);
    check("lit_195_r", r, 0);
    check("lit_195_v", v, 0);

    run_op(8'hD0, 4'hD, lat, q, r, v);
    check("lit_ovf_lat", lat, 2);
    check("lit_ovf_v", v, 1);

    run_op(8'h00, 4'h7, lat, q, r, v);
    check("lit_zero_q", q, 0);
    check("lit_zero_r", r, 0);
    check("lit_zero_v", v, 0);

    run_op(8'h05, 4'h0, lat, q, r, v);
    check("lit_div0_lat", lat, 2);
    check("lit_div0_v", v, 1);
    tick();
    check("lit_div0_single_done", Done, 0);

    // Abort during SUB (third edge after start).
    tick();
    St = 1'b1; Dividend = 8'h87; Divisor = 4'hD;
    tick();
    St = 1'b0;
    @(posedge Clk);
    tick();
    Rst = 1'b1;
    #1;
    check("abort_quotient", Quotient, 0);
    check("abort_remainder", Remainder, 0);
    check("abort_v", V, 0);
    check("abort_idle", Idle, 1);
    check("abort_done", Done, 0);
    tick();
    Rst = 1'b0;
    dones = 0;
    repeat (15) begin
      tick();
      if (Done) dones++;
    end
    check("abort_no_done", dones, 0);
    run_op(8'h87, 4'hD, lat, q, r, v);
    check("after_abort_q", q, 10);
    check("after_abort_r", r, 5);

    // Random operations, mostly non-overflowing.
    for (int i = 0; i < 200; i++) begin
      dv = 4'($urandom_range(0, 15));
      if (dv != 0 && $urandom_range(0, 3) != 0)
        dd = {4'($urandom_range(0, int'(dv) - 1)), 4'($urandom)};
      else
        dd = 8'($urandom);
      run_op(dd, dv, lat, q, r, v);
      check("rand_lat", lat, model_lat(int'(dd), int'(dv)));
    end

    // St held high with inputs changing every cycle.
    St = 1'b1;
    dones = 0;
    for (int c = 0; c < 150; c++) begin
      tick();
      Dividend = 8'($urandom);
      Divisor  = 4'($urandom);
      if (Done) dones++;
    end
    St = 1'b0;
    check("held_st_dones_seen", dones > 0, 1);
    repeat (15) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
